// File: rtl/l2_msg_pkg.sv
// Shared widths, message layout and enums for the PMESH L2 message arbiter.
package l2_msg_pkg;

    localparam int TYPE_W = 8;
    localparam int SRC_W  = 6;
    localparam int TAG_W  = 26;
    localparam int DATA_W = 64;

    localparam logic [TYPE_W-1:0] MSG_WB_REQ = 8'hC;

    typedef enum logic {
        CH_MSG1 = 1'b0,
        CH_MSG3 = 1'b1
    } chan_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic [TYPE_W-1:0] msg_type;
        logic [SRC_W-1:0]  source;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } l2_msg_t;

endpackage

// File: rtl/l2_msg_arbiter_if.sv
// Bundle of the two request channels, the issue slot and the completion strobe.
interface l2_msg_arbiter_if;
    import l2_msg_pkg::*;

    logic              msg1_valid;
    logic              msg1_ready;
    logic [TYPE_W-1:0] msg1_type;
    logic [SRC_W-1:0]  msg1_source;
    logic [TAG_W-1:0]  msg1_tag;
    logic [DATA_W-1:0] msg1_data;

    logic              msg3_valid;
    logic              msg3_ready;
    logic [TYPE_W-1:0] msg3_type;
    logic [SRC_W-1:0]  msg3_source;
    logic [TAG_W-1:0]  msg3_tag;
    logic [DATA_W-1:0] msg3_data;

    logic              issue_valid;
    logic              issue_ready;
    logic              issue_chan;
    logic [TYPE_W-1:0] issue_type;
    logic [SRC_W-1:0]  issue_source;
    logic [TAG_W-1:0]  issue_tag;
    logic [DATA_W-1:0] issue_data;
    logic              issue_is_wb;
    logic              done;
    logic              busy;

    modport slave (
        input  msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
        input  msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
        input  issue_ready, done,
        output msg1_ready, msg3_ready,
        output issue_valid, issue_chan, issue_type, issue_source, issue_tag, issue_data,
        output issue_is_wb, busy
    );

    modport master (
        output msg1_valid, msg1_type, msg1_source, msg1_tag, msg1_data,
        output msg3_valid, msg3_type, msg3_source, msg3_tag, msg3_data,
        output issue_ready, done,
        input  msg1_ready, msg3_ready,
        input  issue_valid, issue_chan, issue_type, issue_source, issue_tag, issue_data,
        input  issue_is_wb, busy
    );

endinterface

// File: rtl/l2_arb_starve_ctr.sv
// Saturating count of msg3 grants taken while msg1 waits; raises forced at the limit.
// Only instantiated when L2_ARB_STARVE_EN is defined.
module l2_arb_starve_ctr #(
    parameter int unsigned LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       msg1_pending,
    input  logic       acc_msg1,
    input  logic       acc_msg3,
    output logic [3:0] cnt,
    output logic       forced
);

    localparam logic [3:0] LIM = 4'(LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (acc_msg1) begin
            cnt <= '0;
        end else if (acc_msg3 && msg1_pending && (cnt != LIM)) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign forced = msg1_pending && (cnt == LIM);

endmodule

// File: rtl/l2_msg_arbiter.sv
// Single-slot front-end scheduler for the L2 datapath: picks msg1 or msg3, holds it until done.
// L2_ARB_STARVE_EN enables the msg1 anti-starvation counter; otherwise msg3 has strict priority.
module l2_msg_arbiter
    import l2_msg_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    l2_msg_arbiter_if.slave  bus
);

    arb_state_e state;
    l2_msg_t    m1_msg, m3_msg, hold;
    chan_e      hold_chan;
    logic       hold_is_wb, issue_valid_q, busy_q;
    logic       forced, grant_m3, acc_m1, acc_m3;

    assign m1_msg = {bus.msg1_type, bus.msg1_source, bus.msg1_tag, bus.msg1_data};
    assign m3_msg = {bus.msg3_type, bus.msg3_source, bus.msg3_tag, bus.msg3_data};

`ifdef L2_ARB_STARVE_EN
    logic [3:0] starve_cnt;

    l2_arb_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg1_pending (bus.msg1_valid),
        .acc_msg1     (acc_m1),
        .acc_msg3     (acc_m3),
        .cnt          (starve_cnt),
        .forced       (forced)
    );
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT;
    assign forced       = 1'b0;
`endif

    // Readys are gated by rst_n so they read 0 while reset is held even with a sender valid.
    assign grant_m3 = bus.msg3_valid && !forced;
    assign acc_m3   = rst_n && (state == IDLE) && grant_m3;
    assign acc_m1   = rst_n && (state == IDLE) && bus.msg1_valid && !grant_m3;

    assign bus.msg3_ready = acc_m3;
    assign bus.msg1_ready = acc_m1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the hold register drives issue_* directly, so it is reset to keep those outputs at 0.
            state         <= IDLE;
            hold          <= '0;
            hold_chan     <= CH_MSG1;
            hold_is_wb    <= 1'b0;
            issue_valid_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc_m3) begin
                        hold          <= m3_msg;
                        hold_chan     <= CH_MSG3;
                        hold_is_wb    <= (m3_msg.msg_type == MSG_WB_REQ);
                        state         <= ISSUE;
                        issue_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end else if (acc_m1) begin
                        hold          <= m1_msg;
                        hold_chan     <= CH_MSG1;
                        hold_is_wb    <= 1'b0;
                        state         <= ISSUE;
                        issue_valid_q <= 1'b1;
                        busy_q        <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.issue_ready) begin
                        state         <= WAIT;
                        issue_valid_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.done) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    issue_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign bus.issue_valid  = issue_valid_q;
    assign bus.issue_chan   = hold_chan;
    assign bus.issue_type   = hold.msg_type;
    assign bus.issue_source = hold.source;
    assign bus.issue_tag    = hold.tag;
    assign bus.issue_data   = hold.data;
    assign bus.issue_is_wb  = hold_is_wb;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_l2_msg_arbiter.sv
// Self-checking bench for l2_msg_arbiter: vector table, scoreboard of issued messages, corner sequences.
module tb_l2_msg_arbiter;
    import l2_msg_pkg::*;

    localparam int unsigned LIMIT = 4;

    typedef struct {
        logic    chan;
        l2_msg_t msg;
        logic    is_wb;
    } exp_t;

    typedef struct {
        logic    m1v;
        logic    m3v;
        l2_msg_t m1;
        l2_msg_t m3;
        logic    exp_m1r;
        logic    exp_m3r;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];

    l2_msg_arbiter_if bus();

    l2_msg_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic l2_msg_t mk(input logic [7:0] t, input logic [5:0] s,
                                   input logic [25:0] g, input logic [63:0] d);
        l2_msg_t m;
        m.msg_type = t;
        m.source   = s;
        m.tag      = g;
        m.data     = d;
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic m1v, input logic m3v, input l2_msg_t m1, input l2_msg_t m3);
        bus.msg1_valid  = m1v;
        bus.msg1_type   = m1.msg_type;
        bus.msg1_source = m1.source;
        bus.msg1_tag    = m1.tag;
        bus.msg1_data   = m1.data;
        bus.msg3_valid  = m3v;
        bus.msg3_type   = m3.msg_type;
        bus.msg3_source = m3.source;
        bus.msg3_tag    = m3.tag;
        bus.msg3_data   = m3.data;
    endtask

    task automatic push_exp(input logic chan, input l2_msg_t m);
        exp_t e;
        e.chan  = chan;
        e.msg   = m;
        e.is_wb = chan && (m.msg_type == 8'h0C);
        exp_q.push_back(e);
    endtask

    // Called just after the accept edge; compares the first issued cycle against the scoreboard.
    task automatic wait_issue(input string name);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!bus.issue_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!bus.issue_valid) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: issue_valid 0 expected 1", name);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: unexpected issue, scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        check({name, " latency"}, 64'(n), 64'd0);
        check({name, " chan"},    bus.issue_chan,   e.chan);
        check({name, " type"},    bus.issue_type,   e.msg.msg_type);
        check({name, " source"},  bus.issue_source, e.msg.source);
        check({name, " tag"},     bus.issue_tag,    e.msg.tag);
        check({name, " data"},    bus.issue_data,   e.msg.data);
        check({name, " is_wb"},   bus.issue_is_wb,  e.is_wb);
        check({name, " busy"},    bus.busy,         1'b1);
    endtask

    // Called at a negedge in ISSUE; handshakes, waits gap cycles in WAIT, pulses done.
    task automatic complete(input string name, input int gap);
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        repeat (gap) tick();
        bus.done = 1'b1;
        @(negedge clk);
        check({name, " wait busy"},  bus.busy,        1'b1);
        check({name, " wait valid"}, bus.issue_valid, 1'b0);
        @(posedge clk);
        #1;
        bus.done = 1'b0;
        @(negedge clk);
        check({name, " idle busy"}, bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t    vecs[8];
        l2_msg_t z, ma, mb, mc, held;
        logic    exp3;

        z  = '0;
        ma = mk(8'h01, 6'h05, 26'h123, 64'hA5);
        mb = mk(8'h0C, 6'h11, 26'h0456, 64'hDEAD);

        vecs[0] = '{1'b1, 1'b0, ma, z, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 1'b1, z, mk(8'h0C, 6'h02, 26'h0777, 64'h1234), 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, mk(8'h03, 6'h09, 26'h0100, 64'h55), mb, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, mk(8'hFF, 6'h3F, 26'h3FFFFFF, 64'hFFFF_FFFF_FFFF_FFFF), z, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, mk(8'h04, 6'h01, 26'h0002, 64'h77), mk(8'h02, 6'h20, 26'h0abc, 64'hBEEF), 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b1, z, mk(8'h0D, 6'h07, 26'h0333, 64'hCAFE), 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b0, mk(8'h0C, 6'h04, 26'h0044, 64'h0C0C), z, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b0, ma, mb, 1'b0, 1'b0};

        bus.issue_ready = 1'b0;
        bus.done        = 1'b0;

        // Reset values, with both senders valid while reset is held.
        set_req(1'b1, 1'b1, ma, mb);
        #1;
        check("rst msg1_ready",  bus.msg1_ready,  1'b0);
        check("rst msg3_ready",  bus.msg3_ready,  1'b0);
        check("rst issue_valid", bus.issue_valid, 1'b0);
        check("rst issue_chan",  bus.issue_chan,  1'b0);
        check("rst issue_type",  bus.issue_type,  8'h00);
        check("rst issue_data",  bus.issue_data,  64'h0);
        check("rst issue_is_wb", bus.issue_is_wb, 1'b0);
        check("rst busy",        bus.busy,        1'b0);
        set_req(1'b0, 1'b0, z, z);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Table of single transactions.
        foreach (vecs[i]) begin
            set_req(vecs[i].m1v, vecs[i].m3v, vecs[i].m1, vecs[i].m3);
            #1;
            check($sformatf("vec%0d msg1_ready", i), bus.msg1_ready, vecs[i].exp_m1r);
            check($sformatf("vec%0d msg3_ready", i), bus.msg3_ready, vecs[i].exp_m3r);
            if (vecs[i].exp_m3r) push_exp(1'b1, vecs[i].m3);
            else if (vecs[i].exp_m1r) push_exp(1'b0, vecs[i].m1);
            tick();
            set_req(1'b0, 1'b0, z, z);
            if (vecs[i].exp_m1r || vecs[i].exp_m3r) begin
                wait_issue($sformatf("vec%0d", i));
                complete($sformatf("vec%0d", i), 1);
            end else begin
                @(negedge clk);
                check($sformatf("vec%0d idle busy", i), bus.busy, 1'b0);
            end
            tick();
        end

        // msg3 wins a tie; msg1, still valid, is taken in the first IDLE cycle afterwards.
        set_req(1'b1, 1'b1, ma, mb);
        #1;
        check("tie msg3_ready", bus.msg3_ready, 1'b1);
        check("tie msg1_ready", bus.msg1_ready, 1'b0);
        push_exp(1'b1, mb);
        tick();
        set_req(1'b1, 1'b0, ma, z);
        wait_issue("tie m3");
        complete("tie m3", 0);
        check("tie next msg1_ready", bus.msg1_ready, 1'b1);
        push_exp(1'b0, ma);
        tick();
        set_req(1'b0, 1'b0, z, z);
        wait_issue("tie m1");
        complete("tie m1", 0);
        tick();

        // Both channels held valid: grant order follows the starvation rule.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        mc = mk(8'h02, 6'h33, 26'h0999, 64'h3333);
        set_req(1'b1, 1'b1, ma, mc);
        @(negedge clk);
        for (int g = 0; g < 10; g++) begin
`ifdef L2_ARB_STARVE_EN
            exp3 = (g % (LIMIT + 1)) != LIMIT;
`else
            exp3 = 1'b1;
`endif
            check($sformatf("starve g%0d msg3_ready", g), bus.msg3_ready, exp3);
            check($sformatf("starve g%0d msg1_ready", g), bus.msg1_ready, !exp3);
            push_exp(exp3, exp3 ? mc : ma);
            tick();
            wait_issue($sformatf("starve g%0d", g));
            complete($sformatf("starve g%0d", g), 0);
        end
        set_req(1'b0, 1'b0, z, z);
        tick();

        // issue_ready held low: slot frozen, inputs ignored.
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        held = mk(8'h21, 6'h2A, 26'h1234567, 64'h0123_4567_89AB_CDEF);
        set_req(1'b1, 1'b0, held, z);
        push_exp(1'b0, held);
        tick();
        set_req(1'b1, 1'b1, ma, mb);
        wait_issue("stall");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d valid", k),  bus.issue_valid, 1'b1);
            check($sformatf("stall%0d chan", k),   bus.issue_chan,  1'b0);
            check($sformatf("stall%0d type", k),   bus.issue_type,  held.msg_type);
            check($sformatf("stall%0d tag", k),    bus.issue_tag,   held.tag);
            check($sformatf("stall%0d data", k),   bus.issue_data,  held.data);
            check($sformatf("stall%0d m1r", k),    bus.msg1_ready,  1'b0);
            check($sformatf("stall%0d m3r", k),    bus.msg3_ready,  1'b0);
        end
        set_req(1'b0, 1'b0, z, z);
        complete("stall", 0);
        tick();

        // done during ISSUE (alone, then together with issue_ready) is ignored.
        set_req(1'b1, 1'b0, ma, z);
        push_exp(1'b0, ma);
        tick();
        set_req(1'b0, 1'b0, z, z);
        wait_issue("done_issue");
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        @(negedge clk);
        check("done_issue still valid", bus.issue_valid, 1'b1);
        bus.issue_ready = 1'b1;
        bus.done        = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        bus.done        = 1'b0;
        set_req(1'b1, 1'b1, ma, mb);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("done_issue wait%0d busy", k),  bus.busy,        1'b1);
            check($sformatf("done_issue wait%0d valid", k), bus.issue_valid, 1'b0);
            check($sformatf("done_issue wait%0d m3r", k),   bus.msg3_ready,  1'b0);
        end
        set_req(1'b0, 1'b0, z, z);
        tick();
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0;
        @(negedge clk);
        check("done_issue idle busy", bus.busy, 1'b0);
        tick();

        // Asynchronous reset while in WAIT, then retry accepted on the first edge.
        set_req(1'b1, 1'b0, ma, z);
        push_exp(1'b0, ma);
        tick();
        wait_issue("rst_wait");
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        check("rst_wait in wait", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_wait issue_valid", bus.issue_valid, 1'b0);
        check("rst_wait busy",        bus.busy,        1'b0);
        check("rst_wait issue_data",  bus.issue_data,  64'h0);
        check("rst_wait msg1_ready",  bus.msg1_ready,  1'b0);
`ifdef L2_ARB_STARVE_EN
        check("rst_wait starve_cnt",  dut.starve_cnt,  4'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_wait retry msg1_ready", bus.msg1_ready, 1'b1);
        push_exp(1'b0, ma);
        @(posedge clk);
        #1;
        set_req(1'b0, 1'b0, z, z);
        wait_issue("rst_wait retry");
        complete("rst_wait retry", 0);

        check("scoreboard drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/l2_msg_arbiter.md
# l2_msg_arbiter

Front-end scheduler for the PMESH L2 single-line datapath. It arbitrates between the core request channel (msg1) and the writeback/response channel (msg3), accepts one message at a time, and presents it to the L2 datapath as a single issue slot. It holds the slot until the datapath signals completion, which serialises all state updates to cache_tag, cache_vd, cache_state, cache_data, cache_owner and share_list.

## Interface
- STARVE_LIMIT, 4: consecutive msg3 grants, with msg1 pending, after which msg1 is forced (range 1..15)
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- msg1_valid / msg1_ready  in / out  1 / 1  core request handshake
- msg1_type, msg1_source, msg1_tag, msg1_data  in  8, 6, 26, 64  core request fields
- msg3_valid / msg3_ready  in / out  1 / 1  writeback/response handshake
- msg3_type, msg3_source, msg3_tag, msg3_data  in  8, 6, 26, 64  writeback fields
- issue_valid  out  1  held message presented to datapath
- issue_ready  in  1  datapath accepts held message
- issue_chan  out  1  0 = msg1, 1 = msg3
- issue_type, issue_source, issue_tag, issue_data  out  8, 6, 26, 64  held fields
- issue_is_wb  out  1  issue_chan == 1 and issue_type == 8'hC (WB_REQ)
- done  in  1  single-cycle pulse: datapath has finished the issued message
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE:
  - grant = msg3 if msg3_valid and not forced, else msg1 if msg1_valid.
  - forced = msg1_valid and starve_cnt == STARVE_LIMIT.
  - msgX_ready is combinational: 1 only in IDLE, only for the granted channel, and only when that channel is valid. The other ready is 0.
- Accept on valid && ready: capture all four fields and the channel into the hold register, then go to ISSUE.
- ISSUE: issue_valid = 1, and the hold register is frozen. On issue_ready, go to WAIT.
- WAIT: issue_valid = 0. On done, go to IDLE. done is ignored in IDLE and ISSUE.
- starve_cnt (4 bits):
  - On a msg3 accept while msg1_valid: increment, saturating at STARVE_LIMIT.
  - On a msg1 accept: clear to 0.
  - Otherwise: hold.
- Decoding of msg types is limited to issue_is_wb. The datapath owns all other semantics.

## Timing
- Reset values:
  - msg1_ready = 0, msg3_ready = 0.
  - issue_valid = 0, issue_chan = 0, issue_* fields = 0, issue_is_wb = 0.
  - busy = 0, state = IDLE, starve_cnt = 0.
- Accept in cycle N gives issue_valid = 1 from cycle N+1.
- If issue_ready and done are both high in cycle M (M ≥ N+1):
  - WAIT is entered at M+1, and the done at M is ignored.
  - done must arrive at or after M+1.
  - IDLE is reached the cycle after done, and the next accept is possible in that same IDLE cycle.
  - Minimum accept-to-accept spacing is 3 cycles.
- Simultaneous msg1_valid and msg3_valid: msg3 wins, unless forced.
- Inputs are sampled only in IDLE. Channel changes while busy have no effect.
- Reset mid-operation: the held message is dropped and all outputs return to reset values immediately (asynchronous). The sender must retry.

## Configuration
- L2_ARB_STARVE_EN:
  - Defined: starve_cnt and forced msg1 grant as described above.
  - Undefined: starve_cnt is not built, forced is tied to 0, and msg3 has strict priority. STARVE_LIMIT is unused.

## Structure
- Package l2_msg_pkg:
  - Width constants: TYPE_W = 8, SRC_W = 6, TAG_W = 26, DATA_W = 64.
  - MSG_WB_REQ = 8'hC.
  - Channel enum: CH_MSG1, CH_MSG3.
  - Arbiter state enum: IDLE, ISSUE, WAIT.
  - Packed l2_msg_t struct {type, source, tag, data}.
- One sub-module, l2_arb_starve_ctr: the saturating counter with a forced output. It is instantiated only under L2_ARB_STARVE_EN.

## Test plan
- Lone msg1 (type 8'h01, tag 26'h123, data 64'hA5):
  - msg1_ready high in cycle 0.
  - issue_valid cycle 1, issue_chan = 0, issue_is_wb = 0.
  - With issue_ready at cycle 1 and done at cycle 3: busy drops at cycle 4.
- Both valid in IDLE, msg3_type 8'hC, msg3_data 64'hDEAD:
  - Only msg3_ready = 1.
  - issue_chan = 1, issue_is_wb = 1, issue_data = 64'hDEAD.
  - msg1 is accepted in the next IDLE cycle.
- With the macro on and STARVE_LIMIT = 4, msg1 and msg3 held valid continuously:
  - Grant order is msg3 ×4, msg1, msg3 ×4, msg1.
  - Without the macro, msg1 is never granted.
- issue_ready low for 5 cycles: issue_valid and all issue_* fields stay stable, and both readys stay 0.
- done pulsed during ISSUE is ignored. The FSM still requires a done in WAIT before returning to IDLE.
- rst_n asserted during WAIT:
  - Same cycle: issue_valid = 0, busy = 0, starve_cnt = 0.
  - After rst_n release, a pending msg1 is accepted on the first edge.
